// File: rtl/mc6502_register_file_gen_if.sv
// Bus bundle for mc6502_register_file_gen: interrupt-logic (il_*), memory
// controller (mc_*), execution controller (ec_*) controls, read-port selects
// and the architectural state outputs. The master drives the control side
// and the slave (the register file) drives the state outputs.
interface mc6502_register_file_gen_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 16
) ();
    // interrupt logic
    logic [DATA_W-1:0] il_data;
    logic              il_set_pcl;
    logic              il_set_pch;
    logic              il_set_i;
    logic              il_set_b;
    logic              il_pushed;
    // memory controller
    logic              mc_fetched;
    logic [PC_W-1:0]   mc_pc;
    logic              mc_set_pc;
    logic              mc_pushed;
    logic              mc_pull;
    logic [DATA_W-1:0] mc_psr;
    logic              mc_set_psr;
    // execution controller
    logic [DATA_W-1:0] ec_data;
    logic              ec_we;
    logic [3:0]        ec_wsel;
    logic              ec_set_s;
    logic              ec_set_pcl;
    logic              ec_set_pch;
    logic [DATA_W-1:0] ec_flags;
    logic [DATA_W-1:0] ec_flag_we;
    // read ports and housekeeping
    logic [3:0]        rd_a_sel;
    logic [3:0]        rd_b_sel;
    logic              wrap_clr;
    logic              bank_swap;
    // state outputs
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] sp;
    logic [DATA_W-1:0] psr;
    logic [DATA_W-1:0] rd_a_data;
    logic [DATA_W-1:0] rd_b_data;
    logic              sp_wrap_dn;
    logic              sp_wrap_up;
    logic              bank_sel;

    modport master (
        output il_data, il_set_pcl, il_set_pch, il_set_i, il_set_b, il_pushed,
        output mc_fetched, mc_pc, mc_set_pc, mc_pushed, mc_pull, mc_psr, mc_set_psr,
        output ec_data, ec_we, ec_wsel, ec_set_s, ec_set_pcl, ec_set_pch, ec_flags, ec_flag_we,
        output rd_a_sel, rd_b_sel, wrap_clr, bank_swap,
        input  pc, sp, psr, rd_a_data, rd_b_data, sp_wrap_dn, sp_wrap_up, bank_sel
    );

    modport slave (
        input  il_data, il_set_pcl, il_set_pch, il_set_i, il_set_b, il_pushed,
        input  mc_fetched, mc_pc, mc_set_pc, mc_pushed, mc_pull, mc_psr, mc_set_psr,
        input  ec_data, ec_we, ec_wsel, ec_set_s, ec_set_pcl, ec_set_pch, ec_flags, ec_flag_we,
        input  rd_a_sel, rd_b_sel, wrap_clr, bank_swap,
        output pc, sp, psr, rd_a_data, rd_b_data, sp_wrap_dn, sp_wrap_up, bank_sel
    );
endinterface

// File: rtl/mc6502_register_file_gen.sv
// Parametrised 6502-style register file: NUM_GPR general registers, PC,
// stack pointer with sticky wrap detection, and status register.
// Optional feature macro: SHADOW_BANK_EN adds a second GPR+PSR bank selected
// by bank_sel and toggled by bank_swap. Without it bank_swap is ignored and
// bank_sel is tied low.
module mc6502_register_file_gen #(
    parameter int                DATA_W   = 8,
    parameter int                PC_W     = 16,
    parameter int                NUM_GPR  = 3,
    parameter logic [PC_W-1:0]   RESET_PC = 16'h0000,
    parameter logic [DATA_W-1:0] SP_RESET = 8'hFF
) (
    input logic                         clk,
    input logic                         rst,
    mc6502_register_file_gen_if.slave   bus
);

`ifdef SHADOW_BANK_EN
    localparam int NUM_BANKS = 2;
`else
    localparam int NUM_BANKS = 1;
`endif

    // I and bit5 set out of reset; bit5 is hard-wired high
    localparam logic [DATA_W-1:0] PSR_RESET = DATA_W'(8'h24);
    localparam int                PSR_I_BIT = 2;
    localparam int                PSR_B_BIT = 4;
    localparam int                PSR_1_BIT = 5;

    logic [PC_W-1:0]   pc_r;
    logic [PC_W-1:0]   pc_next_s;
    logic [DATA_W-1:0] sp_r;
    logic [DATA_W-1:0] sp_next_s;
    logic              wrap_dn_r;
    logic              wrap_up_r;
    logic              wrap_dn_set_s;
    logic              wrap_up_set_s;
    logic              pushed_s;
    logic              pcl_load_s;
    logic              pch_load_s;
    logic [DATA_W-1:0] gpr_r [NUM_BANKS][NUM_GPR];
    logic [DATA_W-1:0] psr_r [NUM_BANKS];
    logic [DATA_W-1:0] psr_cur_s;
    logic [DATA_W-1:0] psr_next_s;
    logic [DATA_W-1:0] rd_a_s;
    logic [DATA_W-1:0] rd_b_s;
    logic              bank_sel_s;

`ifdef SHADOW_BANK_EN
    logic bank_sel_r;

    // Active-bank toggle; writes in the swap cycle still target the old bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_sel_r <= 1'b0;
        end else if (bus.bank_swap) begin
            bank_sel_r <= ~bank_sel_r;
        end else begin
            bank_sel_r <= bank_sel_r;
        end
    end

    assign bank_sel_s = bank_sel_r;
`else
    logic unused_bank_swap_s;
    assign unused_bank_swap_s = bus.bank_swap;
    assign bank_sel_s         = 1'b0;
`endif

    // Select the PSR of the active bank
    always_comb begin
        psr_cur_s = {DATA_W{1'b0}};
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (1'(b) == bank_sel_s) begin
                psr_cur_s = psr_r[b];
            end else begin
                psr_cur_s = psr_cur_s;
            end
        end
    end

    // Next PC: any half load from il/ec freezes fetch and absolute set
    always_comb begin
        pcl_load_s = bus.il_set_pcl | bus.ec_set_pcl;
        pch_load_s = bus.il_set_pch | bus.ec_set_pch;
        pc_next_s  = pc_r;
        if (pcl_load_s || pch_load_s) begin
            if (bus.il_set_pcl) begin
                pc_next_s[DATA_W-1:0] = bus.il_data;
            end else if (bus.ec_set_pcl) begin
                pc_next_s[DATA_W-1:0] = bus.ec_data;
            end else begin
                pc_next_s[DATA_W-1:0] = pc_r[DATA_W-1:0];
            end
            if (bus.il_set_pch) begin
                pc_next_s[PC_W-1:DATA_W] = bus.il_data;
            end else if (bus.ec_set_pch) begin
                pc_next_s[PC_W-1:DATA_W] = bus.ec_data;
            end else begin
                pc_next_s[PC_W-1:DATA_W] = pc_r[PC_W-1:DATA_W];
            end
        end else if (bus.mc_fetched) begin
            pc_next_s = pc_r + PC_W'(1);
        end else if (bus.mc_set_pc) begin
            pc_next_s = bus.mc_pc;
        end else begin
            pc_next_s = pc_r;
        end
    end

    // Next SP and wrap detection; a simultaneous push and pull cancel out
    always_comb begin
        pushed_s      = bus.mc_pushed | bus.il_pushed;
        sp_next_s     = sp_r;
        wrap_dn_set_s = 1'b0;
        wrap_up_set_s = 1'b0;
        if (bus.ec_set_s) begin
            sp_next_s = bus.ec_data;
        end else if (pushed_s && bus.mc_pull) begin
            sp_next_s = sp_r;
        end else if (pushed_s) begin
            sp_next_s     = sp_r - DATA_W'(1);
            wrap_dn_set_s = (sp_r == {DATA_W{1'b0}});
        end else if (bus.mc_pull) begin
            sp_next_s     = sp_r + DATA_W'(1);
            wrap_up_set_s = (sp_r == {DATA_W{1'b1}});
        end else begin
            sp_next_s = sp_r;
        end
    end

    // Next PSR per bit: ec flag write > interrupt force > PSR image load
    always_comb begin
        psr_next_s = psr_cur_s;
        for (int b = 0; b < DATA_W; b++) begin
            if (bus.ec_flag_we[b]) begin
                psr_next_s[b] = bus.ec_flags[b];
            end else if ((b == PSR_I_BIT && bus.il_set_i) || (b == PSR_B_BIT && bus.il_set_b)) begin
                psr_next_s[b] = 1'b1;
            end else if (bus.mc_set_psr) begin
                psr_next_s[b] = bus.mc_psr[b];
            end else begin
                psr_next_s[b] = psr_cur_s[b];
            end
        end
        psr_next_s[PSR_1_BIT] = 1'b1;
    end

    // PC, SP and sticky wrap flags; a new wrap beats wrap_clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r      <= RESET_PC;
            sp_r      <= SP_RESET;
            wrap_dn_r <= 1'b0;
            wrap_up_r <= 1'b0;
        end else begin
            pc_r      <= pc_next_s;
            sp_r      <= sp_next_s;
            wrap_dn_r <= wrap_dn_set_s | (wrap_dn_r & ~bus.wrap_clr);
            wrap_up_r <= wrap_up_set_s | (wrap_up_r & ~bus.wrap_clr);
        end
    end

    // PSR of the active bank; the inactive bank holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                psr_r[b] <= PSR_RESET;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (1'(b) == bank_sel_s) begin
                    psr_r[b] <= psr_next_s;
                end else begin
                    psr_r[b] <= psr_r[b];
                end
            end
        end
    end

    // GPR write; indices at or above NUM_GPR match no register and are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int i = 0; i < NUM_GPR; i++) begin
                    gpr_r[b][i] <= {DATA_W{1'b0}};
                end
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int i = 0; i < NUM_GPR; i++) begin
                    if (bus.ec_we && (1'(b) == bank_sel_s) && (bus.ec_wsel == 4'(i))) begin
                        gpr_r[b][i] <= bus.ec_data;
                    end else begin
                        gpr_r[b][i] <= gpr_r[b][i];
                    end
                end
            end
        end
    end

    // Two zero-latency read ports from the active bank; no write bypass
    always_comb begin
        rd_a_s = {DATA_W{1'b0}};
        rd_b_s = {DATA_W{1'b0}};
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                if ((1'(b) == bank_sel_s) && (bus.rd_a_sel == 4'(i))) begin
                    rd_a_s = gpr_r[b][i];
                end else begin
                    rd_a_s = rd_a_s;
                end
                if ((1'(b) == bank_sel_s) && (bus.rd_b_sel == 4'(i))) begin
                    rd_b_s = gpr_r[b][i];
                end else begin
                    rd_b_s = rd_b_s;
                end
            end
        end
    end

    assign bus.pc         = pc_r;
    assign bus.sp         = sp_r;
    assign bus.psr        = psr_cur_s;
    assign bus.rd_a_data  = rd_a_s;
    assign bus.rd_b_data  = rd_b_s;
    assign bus.sp_wrap_dn = wrap_dn_r;
    assign bus.sp_wrap_up = wrap_up_r;
    assign bus.bank_sel   = bank_sel_s;

endmodule
